lc2k_hazard_ctrl: RTL and testbench

//  Pipeline controller for the 5-stage LC2K core (IF/ID/EX/MEM/WB). Keeps a shadow of op/dest per

---
 rtl/lc2k_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_lc2k_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// lc2k_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage LC2K core (IF/ID/EX/MEM/WB).
// It keeps a small shadow {op, dest, writes} of the instructions sitting in
// EX, MEM and WB and, from those shadows plus the instruction currently in ID,
// decides every cycle whether to stall, flush, which operand source each ID
// operand must take, and whether the front end may keep fetching while a
// HALT drains out of the pipe.
//
// Optional feature macro: LC2K_HAZARD_FWD_EN
//   defined   : EX/MEM/WB forwarding is available; only a load-use pair costs
//               a single bubble.
//   undefined : no forwarding; fwd_a_sel/fwd_b_sel stay 0 and ID stalls while
//               any of EX/MEM/WB still has to write a register ID reads.
//
// Ports
//   clock       in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   id_valid    in   1      instruction in ID is real (0 = treat as NOOP)
//   id_op       in   OP_W   opcode in ID
//   id_regA     in   REG_W  regA field in ID
//   id_regB     in   REG_W  regB field in ID
//   id_destReg  in   REG_W  destReg field in ID
//   br_taken    in   1      BEQ in EX resolved taken this cycle
//   stall       out  1      hold PC and IF/ID, inject NOOP into ID/EX
//   flush       out  1      squash IF/ID and ID/EX on a taken branch
//   fwd_a_sel   out  2      regA source: 0 regfile, 1 EX, 2 MEM, 3 WB
//   fwd_b_sel   out  2      regB source, same encoding
//   fetch_en    out  1      IF may fetch and advance PC
//   halted      out  1      HALT has retired from WB; sticky until reset
//
// All outputs are combinational (zero-cycle latency) from the shadows, the FSM
// state and the ID inputs; the datapath consumes them in the same cycle.
// -----------------------------------------------------------------------------
module lc2k_hazard_ctrl #(
    parameter int REG_W = 3,
    parameter int OP_W  = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_op,
    input  logic [REG_W-1:0] id_regA,
    input  logic [REG_W-1:0] id_regB,
    input  logic [REG_W-1:0] id_destReg,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             fetch_en,
    output logic             halted
);

    // Opcode map of the LC2K ISA.
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JALR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6);
    localparam logic [OP_W-1:0] OP_NOOP = OP_W'(7);

    // Operand source encoding shared by fwd_a_sel and fwd_b_sel.
    localparam logic [1:0] SRC_RF  = 2'd0;
    localparam logic [1:0] SRC_EX  = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;
    localparam logic [1:0] SRC_WB  = 2'd3;

    localparam logic [2:0] DRAIN_LOAD = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dest;
        logic             wr;
    } shadow_t;

    localparam shadow_t SHADOW_NOOP = {OP_NOOP, {REG_W{1'b0}}, 1'b0};

    // ------------------------------------------------------------------
    // Instruction-class helpers
    // ------------------------------------------------------------------

    // ADD/NOR write destReg, LW/JALR write regB.
    function automatic logic op_writes(input logic [OP_W-1:0] op);
        logic w;
        case (op)
            OP_ADD, OP_NOR, OP_LW, OP_JALR: w = 1'b1;
            default:                        w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic [REG_W-1:0] op_dest(input logic [OP_W-1:0]  op,
                                                 input logic [REG_W-1:0] reg_b,
                                                 input logic [REG_W-1:0] dest_reg);
        logic [REG_W-1:0] d;
        case (op)
            OP_LW, OP_JALR: d = reg_b;
            default:        d = dest_reg;
        endcase
        return d;
    endfunction

    function automatic logic op_reads_a(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_NOR, OP_LW, OP_SW, OP_BEQ, OP_JALR: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_reads_b(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_NOR, OP_SW, OP_BEQ: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // A stage only counts as a producer when its stored write flag and its
    // opcode agree, so a corrupted flag on a NOOP/HALT/SW/BEQ never creates a
    // phantom hazard or bogus forward.
    function automatic logic stage_writes(input shadow_t s);
        return s.wr & op_writes(s.op);
    endfunction

    // Youngest producer of register r wins: EX > MEM > WB > regfile.
    function automatic logic [1:0] pick_src(input shadow_t          ex,
                                            input shadow_t          mem,
                                            input shadow_t          wb,
                                            input logic [REG_W-1:0] r,
                                            input logic             rd);
        logic [1:0] sel;
        if (!rd) begin
            sel = SRC_RF;
        end else if (stage_writes(ex) && (ex.dest == r)) begin
            sel = SRC_EX;
        end else if (stage_writes(mem) && (mem.dest == r)) begin
            sel = SRC_MEM;
        end else if (stage_writes(wb) && (wb.dest == r)) begin
            sel = SRC_WB;
        end else begin
            sel = SRC_RF;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    shadow_t     ex_r;
    shadow_t     mem_r;
    shadow_t     wb_r;
    shadow_t     ex_nxt_s;
    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  drain_cnt_r;
    logic [2:0]  drain_cnt_nxt_s;

    logic        id_rd_a_s;
    logic        id_rd_b_s;
    logic [1:0]  src_a_s;
    logic [1:0]  src_b_s;
    logic [1:0]  fwd_a_raw_s;
    logic [1:0]  fwd_b_raw_s;
    logic        hazard_s;
    logic        stall_s;
    logic        flush_s;
    logic        accept_halt_s;

    // Which ID operands are genuinely read (an invalid slot reads nothing).
    always_comb begin
        id_rd_a_s = 1'b0;
        id_rd_b_s = 1'b0;
        if (id_valid) begin
            id_rd_a_s = op_reads_a(id_op);
            id_rd_b_s = op_reads_b(id_op);
        end else begin
            id_rd_a_s = 1'b0;
            id_rd_b_s = 1'b0;
        end
    end

    // Nearest in-flight producer for each ID operand.
    always_comb begin
        src_a_s = pick_src(ex_r, mem_r, wb_r, id_regA, id_rd_a_s);
        src_b_s = pick_src(ex_r, mem_r, wb_r, id_regB, id_rd_b_s);
    end

`ifdef LC2K_HAZARD_FWD_EN
    // With forwarding, only a load whose data is not ready until MEM hurts.
    always_comb begin
        hazard_s    = (ex_r.op == OP_LW) && stage_writes(ex_r) &&
                      ((id_rd_a_s && (ex_r.dest == id_regA)) ||
                       (id_rd_b_s && (ex_r.dest == id_regB)));
        fwd_a_raw_s = src_a_s;
        fwd_b_raw_s = src_b_s;
    end
`else
    // Without forwarding, any pending producer of a read register blocks ID;
    // the regfile has no write-to-read bypass, so WB still counts.
    always_comb begin
        hazard_s    = (src_a_s != SRC_RF) || (src_b_s != SRC_RF);
        fwd_a_raw_s = SRC_RF;
        fwd_b_raw_s = SRC_RF;
    end
`endif

    // Output decode and FSM next state; everything is quiet while in reset.
    always_comb begin
        stall_s         = 1'b0;
        flush_s         = 1'b0;
        fwd_a_sel       = SRC_RF;
        fwd_b_sel       = SRC_RF;
        fetch_en        = 1'b0;
        halted          = 1'b0;
        accept_halt_s   = 1'b0;
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        if (!reset_n) begin
            state_nxt_s     = ST_RUN;
            drain_cnt_nxt_s = 3'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A taken branch squashes ID anyway, so it overrides stall.
                    flush_s       = br_taken;
                    stall_s       = hazard_s & ~br_taken;
                    fwd_a_sel     = fwd_a_raw_s;
                    fwd_b_sel     = fwd_b_raw_s;
                    fetch_en      = 1'b1;
                    accept_halt_s = id_valid && (id_op == OP_HALT) &&
                                    !stall_s && !flush_s;
                    if (accept_halt_s) begin
                        state_nxt_s     = ST_DRAIN;
                        drain_cnt_nxt_s = DRAIN_LOAD;
                    end else begin
                        state_nxt_s     = ST_RUN;
                        drain_cnt_nxt_s = 3'd0;
                    end
                end
                ST_DRAIN: begin
                    // Older instructions still need their operands; a branch
                    // cannot be resolving here, so br_taken is ignored.
                    fwd_a_sel = fwd_a_raw_s;
                    fwd_b_sel = fwd_b_raw_s;
                    // Count 3,2,1: the cycle at 1 is the HALT sitting in WB.
                    if (drain_cnt_r <= 3'd1) begin
                        state_nxt_s     = ST_HALTED;
                        drain_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s     = ST_DRAIN;
                        drain_cnt_nxt_s = drain_cnt_r - 3'd1;
                    end
                end
                ST_HALTED: begin
                    halted          = 1'b1;
                    state_nxt_s     = ST_HALTED;
                    drain_cnt_nxt_s = 3'd0;
                end
                default: begin
                    state_nxt_s     = ST_RUN;
                    drain_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    assign stall = stall_s;
    assign flush = flush_s;

    // Shadow entering EX: a bubble unless ID really advances this cycle.
    always_comb begin
        if ((state_r != ST_RUN) || stall_s || flush_s || !id_valid) begin
            ex_nxt_s = SHADOW_NOOP;
        end else begin
            ex_nxt_s = {id_op, op_dest(id_op, id_regB, id_destReg), op_writes(id_op)};
        end
    end

    // Shadow pipeline registers advance unconditionally every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_r  <= SHADOW_NOOP;
            mem_r <= SHADOW_NOOP;
            wb_r  <= SHADOW_NOOP;
        end else begin
            ex_r  <= ex_nxt_s;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_lc2k_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for lc2k_hazard_ctrl. A reference model keeps the last
// three instructions that entered EX as plain records and derives the expected
// controls from the ISA read/write rules; a compare process checks every
// negedge, and directed scenarios pin literal values first, then random
// traffic with occasional HALTs and resets follows.
// -----------------------------------------------------------------------------
module tb_lc2k_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [2:0] id_op;
    logic [2:0] id_regA;
    logic [2:0] id_regB;
    logic [2:0] id_destReg;
    logic       br_taken;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       fetch_en;
    logic       halted;

    lc2k_hazard_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .id_valid   (id_valid),
        .id_op      (id_op),
        .id_regA    (id_regA),
        .id_regB    (id_regB),
        .id_destReg (id_destReg),
        .br_taken   (br_taken),
        .stall      (stall),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .fetch_en   (fetch_en),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // History of what entered EX: index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0] m_op  [3];
    logic [2:0] m_rb  [3];
    logic [2:0] m_dst [3];
    int         m_mode;   // 0 running, 1 draining, 2 halted

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fe;
        logic       h;
    } exp_t;

    // Register written by an instruction, or -1.
    function automatic int wreg(input logic [2:0] op, input logic [2:0] rb, input logic [2:0] dst);
        if (op == 3'd0 || op == 3'd1) return int'(dst);
        if (op == 3'd2 || op == 3'd5) return int'(rb);
        return -1;
    endfunction

    function automatic int src_of(input int r);
        for (int s = 0; s < 3; s++)
            if (wreg(m_op[s], m_rb[s], m_dst[s]) == r) return s + 1;
        return 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   ra, rb, raw;
        int   sa, sb;
        e = '0;
        if (!reset_n) return e;
        if (m_mode == 2) begin
            e.h = 1'b1;
            return e;
        end
        ra = id_valid && (id_op <= 3'd5);
        rb = id_valid && (id_op <= 3'd4) && (id_op != 3'd2);
        sa = ra ? src_of(int'(id_regA)) : 0;
        sb = rb ? src_of(int'(id_regB)) : 0;
`ifdef LC2K_HAZARD_FWD_EN
        e.fa = sa[1:0];
        e.fb = sb[1:0];
        raw  = (m_op[0] == 3'd2) &&
               ((ra && (m_rb[0] == id_regA)) || (rb && (m_rb[0] == id_regB)));
`else
        raw  = (sa != 0) || (sb != 0);
`endif
        if (m_mode == 0) begin
            e.fe    = 1'b1;
            e.flush = br_taken;
            e.stall = raw && !br_taken;
        end
        return e;
    endfunction

    function automatic bit m_enter();
        exp_t e;
        e = model_out();
        return (m_mode == 0) && id_valid && !e.stall && !e.flush;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 3; s++) begin
                m_op[s]  <= 3'd7;
                m_rb[s]  <= 3'd0;
                m_dst[s] <= 3'd0;
            end
            m_mode <= 0;
        end else begin
            m_op[0]  <= m_enter() ? id_op : 3'd7;
            m_rb[0]  <= id_regB;
            m_dst[0] <= id_destReg;
            for (int s = 1; s < 3; s++) begin
                m_op[s]  <= m_op[s-1];
                m_rb[s]  <= m_rb[s-1];
                m_dst[s] <= m_dst[s-1];
            end
            if (m_mode == 1 && m_op[2] == 3'd6) m_mode <= 2;
            else if (m_mode == 0 && m_enter() && id_op == 3'd6) m_mode <= 1;
        end
    end

    task automatic compare_all();
        exp_t e;
        e = model_out();
        check("stall",     stall,     e.stall);
        check("flush",     flush,     e.flush);
        check("fwd_a_sel", fwd_a_sel, e.fa);
        check("fwd_b_sel", fwd_b_sel, e.fb);
        check("fetch_en",  fetch_en,  e.fe);
        check("halted",    halted,    e.h);
    endtask

    always @(negedge clock) if (chk_on) compare_all();

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input bit v, input int op, input int a, input int b, input int d, input bit br);
        id_valid   = v;
        id_op      = 3'(op);
        id_regA    = 3'(a);
        id_regB    = 3'(b);
        id_destReg = 3'(d);
        br_taken   = br;
    endtask

    // One cycle with the given ID contents; returns just after the negedge.
    task automatic cyc(input bit v, input int op, input int a, input int b, input int d, input bit br);
        tick();
        set_id(v, op, a, b, d, br);
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 7, 0, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_id(1'b0, 7, 0, 0, 0, 1'b0);
        tick();
        chk_on = 1'b1;
        tick();
        set_id(1'b1, 0, 1, 1, 1, 1'b1);
        @(negedge clock); #1;
        check("rst_fetch_en", fetch_en, 0);
        check("rst_flush",    flush,    0);
        check("rst_halted",   halted,   0);
        tick();
        reset_n = 1'b1;
        set_id(1'b0, 7, 0, 0, 0, 1'b0);
        @(negedge clock); #1;
        check("run_fetch_en", fetch_en, 1);

        // Back-to-back dependent ADDs.
        idle(3);
        cyc(1'b1, 0, 1, 2, 3, 1'b0);
        check("t1_first_stall", stall, 0);
        cyc(1'b1, 0, 3, 3, 4, 1'b0);
`ifdef LC2K_HAZARD_FWD_EN
        check("t1_stall", stall, 0);
        check("t1_fwd_a", fwd_a_sel, 1);
        check("t1_fwd_b", fwd_b_sel, 1);
`else
        check("t3_stall_c1", stall, 1);
        cyc(1'b1, 0, 3, 3, 4, 1'b0);
        check("t3_stall_c2", stall, 1);
        cyc(1'b1, 0, 3, 3, 4, 1'b0);
        check("t3_stall_c3", stall, 1);
        cyc(1'b1, 0, 3, 3, 4, 1'b0);
        check("t3_stall_done", stall, 0);
        check("t3_fwd_a", fwd_a_sel, 0);
        cyc(1'b1, 0, 4, 4, 5, 1'b0);
        check("t3_add_in_ex", stall, 1);
`endif

        // Load-use.
        idle(3);
        cyc(1'b1, 2, 0, 5, 0, 1'b0);
        check("t2_lw_stall", stall, 0);
        cyc(1'b1, 0, 5, 1, 6, 1'b0);
        check("t2_use_stall", stall, 1);
`ifdef LC2K_HAZARD_FWD_EN
        cyc(1'b1, 0, 5, 1, 6, 1'b0);
        check("t2_after_stall", stall, 0);
        check("t2_fwd_a", fwd_a_sel, 2);
        check("t2_fwd_b", fwd_b_sel, 0);
`else
        cyc(1'b1, 0, 5, 1, 6, 1'b0);
        check("t2_stall_c2", stall, 1);
        cyc(1'b1, 0, 5, 1, 6, 1'b0);
        check("t2_stall_c3", stall, 1);
        cyc(1'b1, 0, 5, 1, 6, 1'b0);
        check("t2_after_stall", stall, 0);
`endif

        // Taken branch with a load-use hazard in ID.
        idle(3);
        cyc(1'b1, 2, 0, 2, 0, 1'b0);
        cyc(1'b1, 0, 2, 2, 1, 1'b1);
        check("t4_flush", flush, 1);
        check("t4_stall", stall, 0);
        cyc(1'b1, 0, 1, 1, 0, 1'b0);
        check("t4_ex_noop_stall", stall, 0);
        check("t4_ex_noop_fwd", fwd_a_sel, 0);

        // HALT drain.
        idle(3);
        cyc(1'b1, 6, 0, 0, 0, 1'b0);
        check("t5_accept_fetch", fetch_en, 1);
        check("t5_accept_stall", stall, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 7, 0, 0, 0, 1'b0);
            check($sformatf("t5_drain%0d_fetch", i), fetch_en, 0);
            check($sformatf("t5_drain%0d_halted", i), halted, 0);
        end
        cyc(1'b0, 7, 0, 0, 0, 1'b0);
        check("t5_halted", halted, 1);
        check("t5_halted_fetch", fetch_en, 0);

        // Reset in HALTED, then again mid-drain.
        tick();
        reset_n = 1'b0;
        @(negedge clock); #1;
        check("t6_rst_halted", halted, 0);
        tick();
        reset_n = 1'b1;
        idle(3);
        cyc(1'b1, 6, 0, 0, 0, 1'b0);
        idle(2);
        tick();
        reset_n = 1'b0;
        set_id(1'b1, 0, 1, 1, 1, 1'b1);
        @(negedge clock); #1;
        check("t6_rst_flush", flush, 0);
        check("t6_rst_fetch", fetch_en, 0);
        tick();
        reset_n = 1'b1;
        set_id(1'b1, 0, 1, 2, 3, 1'b0);
        @(negedge clock); #1;
        check("t6_fetch_en", fetch_en, 1);
        check("t6_halted", halted, 0);
        check("t6_fwd_a", fwd_a_sel, 0);
        check("t6_fwd_b", fwd_b_sel, 0);
        idle(5);
        check("t6_still_run", fetch_en, 1);
        check("t6_still_not_halted", halted, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            int op;
            tick();
            if (!reset_n) reset_n = 1'b1;
            else if (m_mode == 2 || $urandom_range(0, 249) == 0) reset_n = 1'b0;
            op = $urandom_range(0, 6);
            if (op == 6) op = 7;
            if ($urandom_range(0, 47) == 0) op = 6;
            set_id($urandom_range(0, 7) != 0, op,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   (m_mode == 0) && ($urandom_range(0, 7) == 0));
        end
        tick();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
